mdu_seq: RTL



---
 rtl/mdu_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Sequential MIPS multiply/divide unit: shift-add multiply, restoring divide, HI/LO.
// Optional single-cycle multiplier path selected by MDU_FAST_MUL_EN.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               isdiv_q, isdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               dz_q, dz_d;

    logic               go, sgn, is_mul, is_div;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, trial, diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_n, quo, rem;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    assign go     = start && (state_q == IDLE) && !cancel;
    assign sgn    = (op == OP_MULT) || (op == OP_DIV);
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign mag_a  = (sgn && A[WIDTH-1]) ? -A : A;
    assign mag_b  = (sgn && B[WIDTH-1]) ? -B : B;

    // multiplier sits in the low half and is consumed LSB first
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // remainder in the high half, dividend shifts out / quotient shifts in below
    assign trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = trial - {1'b0, opnd_q};
    assign ge       = trial >= {1'b0, opnd_q};
    assign rem_n    = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign div_next = {rem_n, acc_q[WIDTH-2:0], ge};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        isdiv_d = isdiv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        ack_d   = 1'b0;
        done_d  = ack_q;
        unique case (state_q)
            IDLE: begin
                if (go && is_mul) begin
                    state_d = MUL;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    opnd_d  = mag_a;
                    neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d  = 1'b0;
                    isdiv_d = 1'b0;
                    dz_d    = 1'b0;
                end else if (go && is_div) begin
                    if (B == '0) begin
                        dz_d  = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        state_d = DIV;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                        neg_d   = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg_d  = sgn && A[WIDTH-1];
                        isdiv_d = 1'b1;
                        dz_d    = 1'b0;
                    end
                end else if (go && (op == OP_MTHI)) begin
                    hi_d  = A;
                    ack_d = 1'b1;
                    dz_d  = 1'b0;
                end else if (go && (op == OP_MTLO)) begin
                    lo_d  = A;
                    ack_d = 1'b1;
                    dz_d  = 1'b0;
                end
            end
            MUL: begin
`ifdef MDU_FAST_MUL_EN
                acc_d   = fast_prod;
                state_d = FIX;
`else
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = FIX;
`endif
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (isdiv_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
        // flush drops the operation without touching HI/LO
        if (cancel && (state_q != IDLE)) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = ack_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            isdiv_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            isdiv_q <= isdiv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
endmodule
